// File: rtl/restoring_div_if.sv
// Handshake and data bundle for restoring_div.
// The slave modport is the divider side; master is the side that issues
// operands and consumes results.
interface restoring_div_if #(
  parameter int BITS     = 256,
  parameter int CTL_BITS = 8
);
  logic [2*BITS-1:0]   i_dat_a;
  logic [BITS-1:0]     i_dat_b;
  logic                i_val;
  logic [CTL_BITS-1:0] i_ctl;
  logic                o_rdy;
  logic                o_val;
  logic [CTL_BITS-1:0] o_ctl;
  logic [2*BITS-1:0]   o_quo;
  logic [BITS-1:0]     o_rem;
  logic                o_err;
  logic                i_rdy;

  modport slave (
    input  i_dat_a, i_dat_b, i_val, i_ctl, i_rdy,
    output o_rdy, o_val, o_ctl, o_quo, o_rem, o_err
  );

  modport master (
    output i_dat_a, i_dat_b, i_val, i_ctl, i_rdy,
    input  o_rdy, o_val, o_ctl, o_quo, o_rem, o_err
  );
endinterface

// File: rtl/restoring_div.sv
// Multi-cycle radix-2 restoring unsigned divider: 2*BITS dividend by a
// BITS divisor, one quotient bit per clock, one operation in flight.
// Optional feature macro: RESTORING_DIV_EARLY_OUT_EN -- when defined, a
// dividend smaller than a non-zero divisor completes without iterating.
module restoring_div #(
  parameter int BITS     = 256,
  parameter int CTL_BITS = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  restoring_div_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = $clog2(2*BITS+1);

  logic [1:0]          state;
  logic [2*BITS-1:0]   quo;
  logic [BITS:0]       rem;
  logic [BITS-1:0]     dvs;
  logic [CTL_BITS-1:0] ctl;
  logic                err;
  logic                val;
  logic [CNT_W-1:0]    cnt;

  logic [2*BITS-1:0]   quo_nxt;
  logic [BITS:0]       rem_nxt;

  // One restoring iteration: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The partial remainder
  // carries one extra bit so the shifted value never overflows the compare.
  function automatic logic [3*BITS:0] div_step(
    input logic [BITS:0]     r,
    input logic [2*BITS-1:0] q,
    input logic [BITS-1:0]   d
  );
    logic [BITS:0] p;
    p = {r[BITS-1:0], q[2*BITS-1]};
    if (p >= {1'b0, d})
      return {p - {1'b0, d}, q[2*BITS-2:0], 1'b1};
    else
      return {p, q[2*BITS-2:0], 1'b0};
  endfunction

  assign {rem_nxt, quo_nxt} = div_step(rem, quo, dvs);

  assign bus.o_rdy = (state == IDLE);
  assign bus.o_val = val;
  assign bus.o_ctl = ctl;
  assign bus.o_quo = quo;
  assign bus.o_rem = rem[BITS-1:0];
  assign bus.o_err = err;

  // Control FSM and datapath: accept, iterate, then hold the result until taken.
  // Short-path results (divide-by-zero, early-out) are loaded on accept and
  // o_val follows one edge later, giving them a fixed latency of one clock.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      ctl   <= '0;
      err   <= 1'b0;
      val   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_val) begin
            quo <= bus.i_dat_a;
            dvs <= bus.i_dat_b;
            ctl <= bus.i_ctl;
            rem <= '0;
            err <= 1'b0;
            cnt <= CNT_W'(2*BITS);
            if (bus.i_dat_b == '0) begin
              state <= DONE;
              quo   <= '1;
              rem   <= {1'b0, bus.i_dat_a[BITS-1:0]};
              err   <= 1'b1;
            end
`ifdef RESTORING_DIV_EARLY_OUT_EN
            else if (bus.i_dat_a < {{BITS{1'b0}}, bus.i_dat_b}) begin
              state <= DONE;
              quo   <= '0;
              rem   <= {1'b0, bus.i_dat_a[BITS-1:0]};
            end
`endif
            else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            val   <= 1'b1;
          end
        end
        DONE: begin
          if (!val) begin
            val <= 1'b1;
          end else if (bus.i_rdy) begin
            state <= IDLE;
            val   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          val   <= 1'b0;
        end
      endcase
    end
  end

endmodule
